// File: rtl/turbosound_pkg.sv
// Shared types and constants for the TurboSound-style multi-chip bus front end and mixer.
package turbosound_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAcc,
    StMix,
    StOut
  } mix_state_e;

  localparam logic [3:0] SelByteCode  = 4'hF;
  localparam logic [3:0] ModeByteCode = 4'hE;

  localparam int unsigned PsgAccW = 11;
  localparam int unsigned FmAccW  = 13;
  localparam int unsigned MixW    = 14;

endpackage

// File: rtl/turbosound_mixer.sv
// Walks the chips one per cycle, accumulating PSG and FM levels, then mixes and saturates.
module turbosound_mixer
  import turbosound_pkg::*;
#(
  parameter int unsigned NumChips = 2,
  parameter int unsigned OutW     = 12
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         sample_ce_i,
  input  logic                         fm_ena_i,
  input  logic                         acb_i,
  input  logic [8*NumChips-1:0]        psg_a_i,
  input  logic [8*NumChips-1:0]        psg_b_i,
  input  logic [8*NumChips-1:0]        psg_c_i,
  input  logic [16*NumChips-1:0]       fm_i,
  output logic signed [OutW-1:0]       chan_l_o,
  output logic signed [OutW-1:0]       chan_r_o,
  output logic                         out_valid_o,
  output logic                         busy_o
);

  localparam logic [2:0] LastChip = 3'(NumChips - 1);
  localparam logic signed [16:0] SatMax = 17'((1 << (OutW - 1)) - 1);
  localparam logic signed [16:0] SatMin = ~SatMax;

  mix_state_e state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [PsgAccW-1:0] acc_a_q, acc_a_d, acc_b_q, acc_b_d, acc_c_q, acc_c_d;
  logic signed [FmAccW-1:0] acc_fm_q, acc_fm_d;
  logic [OutW-1:0] chan_l_q, chan_l_d, chan_r_q, chan_r_d;

  logic [7:0] chip_a, chip_b, chip_c;
  logic [9:0] chip_fm;
  logic [MixW-1:0] mix_l, mix_r;
  logic signed [16:0] fm_term, sum_l, sum_r;

  function automatic logic [OutW-1:0] sat(input logic signed [16:0] v);
    if (v > SatMax) return SatMax[OutW-1:0];
    if (v < SatMin) return SatMin[OutW-1:0];
    return v[OutW-1:0];
  endfunction

  always_comb begin
    chip_a  = '0;
    chip_b  = '0;
    chip_c  = '0;
    chip_fm = '0;
    for (int unsigned i = 0; i < NumChips; i++) begin
      if (cnt_q == 3'(i)) begin
        chip_a  = psg_a_i[8*i +: 8];
        chip_b  = psg_b_i[8*i +: 8];
        chip_c  = psg_c_i[8*i +: 8];
        chip_fm = fm_i[16*i+6 +: 10];
      end
    end
  end

  // ACB swaps the roles of B and C so C becomes the centre channel.
  always_comb begin
    if (acb_i) begin
      mix_l = {2'b0, acc_a_q, 1'b0} + {3'b0, acc_c_q};
      mix_r = {2'b0, acc_b_q, 1'b0} + {3'b0, acc_c_q};
    end else begin
      mix_l = {2'b0, acc_a_q, 1'b0} + {3'b0, acc_b_q};
      mix_r = {2'b0, acc_c_q, 1'b0} + {3'b0, acc_b_q};
    end
    fm_term = fm_ena_i ? {{4{acc_fm_q[FmAccW-1]}}, acc_fm_q} : '0;
    sum_l   = $signed({3'b0, mix_l}) + fm_term;
    sum_r   = $signed({3'b0, mix_r}) + fm_term;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_a_d  = acc_a_q;
    acc_b_d  = acc_b_q;
    acc_c_d  = acc_c_q;
    acc_fm_d = acc_fm_q;
    chan_l_d = chan_l_q;
    chan_r_d = chan_r_q;
    unique case (state_q)
      StIdle: begin
        if (sample_ce_i) begin
          state_d  = StAcc;
          cnt_d    = '0;
          acc_a_d  = '0;
          acc_b_d  = '0;
          acc_c_d  = '0;
          acc_fm_d = '0;
        end
      end
      StAcc: begin
        acc_a_d  = acc_a_q + PsgAccW'(chip_a);
        acc_b_d  = acc_b_q + PsgAccW'(chip_b);
        acc_c_d  = acc_c_q + PsgAccW'(chip_c);
        acc_fm_d = acc_fm_q + {{3{chip_fm[9]}}, chip_fm};
        if (cnt_q == LastChip) begin
          state_d = StMix;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      StMix: begin
        chan_l_d = sat(sum_l);
        chan_r_d = sat(sum_r);
        state_d  = StOut;
      end
      StOut: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      acc_a_q  <= '0;
      acc_b_q  <= '0;
      acc_c_q  <= '0;
      acc_fm_q <= '0;
      chan_l_q <= '0;
      chan_r_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_a_q  <= acc_a_d;
      acc_b_q  <= acc_b_d;
      acc_c_q  <= acc_c_d;
      acc_fm_q <= acc_fm_d;
      chan_l_q <= chan_l_d;
      chan_r_q <= chan_r_d;
    end
  end

  assign chan_l_o    = chan_l_q;
  assign chan_r_o    = chan_r_q;
  assign out_valid_o = (state_q == StOut);
  assign busy_o      = (state_q != StIdle);

endmodule

// File: rtl/turbosound_n.sv
// Multi-chip sound bus front end: synchronises the CPU bus, decodes select/mode/address/data
// writes, and feeds the mixer. TS_STEREO_MODE_EN enables the ACB stereo mode bit.
module turbosound_n
  import turbosound_pkg::*;
#(
  parameter int unsigned NUM_CHIPS = 2,
  parameter int unsigned OUT_W     = 12
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     BDIR,
  input  logic                     BC,
  input  logic [7:0]               DI,
  input  logic                     SAMPLE_CE,
  input  logic [8*NUM_CHIPS-1:0]   PSG_A,
  input  logic [8*NUM_CHIPS-1:0]   PSG_B,
  input  logic [8*NUM_CHIPS-1:0]   PSG_C,
  input  logic [16*NUM_CHIPS-1:0]  FM,
  input  logic [8*NUM_CHIPS-1:0]   CHIP_DO,
  output logic [NUM_CHIPS-1:0]     CS_N,
  output logic                     WR_N,
  output logic                     ADDR,
  output logic [7:0]               DIN,
  output logic [7:0]               DO,
  output logic signed [OUT_W-1:0]  CHANNEL_L,
  output logic signed [OUT_W-1:0]  CHANNEL_R,
  output logic                     OUT_VALID,
  output logic                     BUSY
);

  logic bdir_s1_q, bdir_s2_q, bdir_hist_q;
  logic bc_s1_q, bc_s2_q;
  logic [7:0] di_s1_q, di_s2_q;

  logic [2:0] sel_q, sel_d;
  logic stat_sel_q, stat_sel_d;
  logic fm_ena_q, fm_ena_d;
  logic access_q, access_d;
  logic acb_q, acb_d;
  logic wr_n_q, wr_n_d;
  logic [7:0] din_q, din_d;

  logic bus_wr;
  logic addr_fwd;
  logic [2:0] sel_idx;
  logic [NUM_CHIPS-1:0] cs_n;
  logic [7:0] rd_mux;

  always_comb begin
    sel_d      = sel_q;
    stat_sel_d = stat_sel_q;
    fm_ena_d   = fm_ena_q;
    access_d   = access_q;
    acb_d      = acb_q;
    din_d      = din_q;
    wr_n_d     = 1'b1;
    addr_fwd   = 1'b0;
    bus_wr     = bdir_s2_q & ~bdir_hist_q;
    sel_idx    = ~di_s2_q[2:0];
    if (bus_wr) begin
      din_d = di_s2_q;
      if (bc_s2_q) begin
        if (di_s2_q[7:4] == SelByteCode) begin
          if (32'(sel_idx) < NUM_CHIPS) sel_d = sel_idx;
          access_d = 1'b0;
        end else if (di_s2_q[7:4] == ModeByteCode) begin
          stat_sel_d = di_s2_q[0];
          fm_ena_d   = ~di_s2_q[1];
`ifdef TS_STEREO_MODE_EN
          acb_d      = di_s2_q[2];
`else
          acb_d      = 1'b0;
`endif
        end else begin
          // PSG registers (high nibble 0) always reach the chip; FM registers only when enabled.
          addr_fwd = (di_s2_q[7:4] == 4'h0) || fm_ena_q;
          access_d = addr_fwd;
          wr_n_d   = ~addr_fwd;
        end
      end else begin
        wr_n_d = ~access_q;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      bdir_s1_q   <= 1'b0;
      bdir_s2_q   <= 1'b0;
      bdir_hist_q <= 1'b0;
      bc_s1_q     <= 1'b0;
      bc_s2_q     <= 1'b0;
      di_s1_q     <= '0;
      di_s2_q     <= '0;
      sel_q       <= '0;
      stat_sel_q  <= 1'b1;
      fm_ena_q    <= 1'b0;
      access_q    <= 1'b0;
      acb_q       <= 1'b0;
      wr_n_q      <= 1'b1;
      din_q       <= '0;
    end else begin
      bdir_s1_q   <= BDIR;
      bdir_s2_q   <= bdir_s1_q;
      bdir_hist_q <= bdir_s2_q;
      bc_s1_q     <= BC;
      bc_s2_q     <= bc_s1_q;
      di_s1_q     <= DI;
      di_s2_q     <= di_s1_q;
      sel_q       <= sel_d;
      stat_sel_q  <= stat_sel_d;
      fm_ena_q    <= fm_ena_d;
      access_q    <= access_d;
      acb_q       <= acb_d;
      wr_n_q      <= wr_n_d;
      din_q       <= din_d;
    end
  end

  always_comb begin
    cs_n   = '1;
    rd_mux = '0;
    for (int unsigned i = 0; i < NUM_CHIPS; i++) begin
      if (sel_q == 3'(i)) begin
        cs_n[i] = 1'b0;
        rd_mux  = CHIP_DO[8*i +: 8];
      end
    end
  end

  assign CS_N = cs_n;
  assign DO   = rd_mux;
  assign WR_N = wr_n_q;
  assign DIN  = din_q;
  assign ADDR = (bdir_s2_q | ~wr_n_q) ? ~bc_s2_q : stat_sel_q;

  turbosound_mixer #(
    .NumChips (NUM_CHIPS),
    .OutW     (OUT_W)
  ) u_mixer (
    .clk_i       (CLK),
    .rst_i       (RESET),
    .sample_ce_i (SAMPLE_CE),
    .fm_ena_i    (fm_ena_q),
    .acb_i       (acb_q),
    .psg_a_i     (PSG_A),
    .psg_b_i     (PSG_B),
    .psg_c_i     (PSG_C),
    .fm_i        (FM),
    .chan_l_o    (CHANNEL_L),
    .chan_r_o    (CHANNEL_R),
    .out_valid_o (OUT_VALID),
    .busy_o      (BUSY)
  );

endmodule

// File: tb/tb_turbosound_n.sv
// Directed bus-decode checks plus randomized mixing against a sum-and-clamp reference model.
module tb_turbosound_n;

  localparam int N = 2;
  localparam int W = 12;

  logic CLK = 1'b0, RESET = 1'b1, BDIR = 1'b0, BC = 1'b0, SAMPLE_CE = 1'b0;
  logic [7:0] DI = '0;
  logic [8*N-1:0] PSG_A = '0, PSG_B = '0, PSG_C = '0, CHIP_DO = '0;
  logic [16*N-1:0] FM = '0;
  logic [N-1:0] CS_N;
  logic WR_N, ADDR, OUT_VALID, BUSY;
  logic [7:0] DIN, DO;
  logic signed [W-1:0] CHANNEL_L, CHANNEL_R;

  turbosound_n #(
    .NUM_CHIPS (N),
    .OUT_W     (W)
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .BDIR      (BDIR),
    .BC        (BC),
    .DI        (DI),
    .SAMPLE_CE (SAMPLE_CE),
    .PSG_A     (PSG_A),
    .PSG_B     (PSG_B),
    .PSG_C     (PSG_C),
    .FM        (FM),
    .CHIP_DO   (CHIP_DO),
    .CS_N      (CS_N),
    .WR_N      (WR_N),
    .ADDR      (ADDR),
    .DIN       (DIN),
    .DO        (DO),
    .CHANNEL_L (CHANNEL_L),
    .CHANNEL_R (CHANNEL_R),
    .OUT_VALID (OUT_VALID),
    .BUSY      (BUSY)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int passed = 0;
  int a[N], b[N], c[N], f[N];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_ch(input string tag, input logic [W-1:0] obs, input int exp);
    logic [W-1:0] e;
    e = W'(exp);
    check(tag, 32'(obs), 32'(e));
  endtask

  function automatic int clamp(input int v);
    int hi, lo;
    hi = (1 << (W - 1)) - 1;
    lo = -(1 << (W - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  // ABC stereo: L = 2A + B (+FM), R = 2C + B (+FM); FM contributes its top 10 bits per chip.
  function automatic int model(input bit left, input bit fm_en);
    int sa, sb, sc, sf;
    sa = 0; sb = 0; sc = 0; sf = 0;
    for (int i = 0; i < N; i++) begin
      sa += a[i];
      sb += b[i];
      sc += c[i];
      sf += f[i] >>> 6;
    end
    return clamp((left ? 2 * sa : 2 * sc) + sb + (fm_en ? sf : 0));
  endfunction

  task automatic apply_inputs();
    for (int i = 0; i < N; i++) begin
      PSG_A[8*i +: 8]  = a[i][7:0];
      PSG_B[8*i +: 8]  = b[i][7:0];
      PSG_C[8*i +: 8]  = c[i][7:0];
      FM[16*i +: 16]   = f[i][15:0];
    end
  endtask

  task automatic bus_write(input logic bc, input logic [7:0] d, output int pulses,
                           output logic addr_seen);
    @(negedge CLK);
    BDIR = 1'b1;
    BC = bc;
    DI = d;
    pulses = 0;
    addr_seen = 1'bx;
    repeat (6) begin
      @(negedge CLK);
      if (WR_N === 1'b0) begin
        pulses++;
        addr_seen = ADDR;
      end
    end
    BDIR = 1'b0;
    repeat (4) @(negedge CLK);
  endtask

  task automatic sample(output int lat);
    @(negedge CLK);
    SAMPLE_CE = 1'b1;
    @(negedge CLK);
    SAMPLE_CE = 1'b0;
    lat = 1;
    while (OUT_VALID !== 1'b1 && lat < 20) begin
      @(negedge CLK);
      lat++;
    end
  endtask

  initial begin
    int pulses, lat, nvalid, vl, vr;
    logic addr_seen;
    bit fm_en;

    CHIP_DO = 16'hB4A5;
    repeat (3) @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    check("rst_cs_n", 32'(CS_N), 32'h2);
    check("rst_wr_n", 32'(WR_N), 32'h1);
    check("rst_din", 32'(DIN), 32'h0);
    check("rst_addr", 32'(ADDR), 32'h1);
    check("rst_valid", 32'(OUT_VALID), 32'h0);
    check("rst_busy", 32'(BUSY), 32'h0);
    check_ch("rst_l", CHANNEL_L, 0);
    check_ch("rst_r", CHANNEL_R, 0);
    check("rst_do", 32'(DO), 32'hA5);

    bus_write(1'b1, 8'hFE, pulses, addr_seen);
    check("sel1_cs_n", 32'(CS_N), 32'h1);
    check("sel1_pulses", pulses, 0);
    check("sel1_do", 32'(DO), 32'hB4);
    bus_write(1'b1, 8'hF9, pulses, addr_seen);
    check("sel6_cs_n", 32'(CS_N), 32'h1);
    bus_write(1'b1, 8'hFF, pulses, addr_seen);
    check("sel0_cs_n", 32'(CS_N), 32'h2);

    bus_write(1'b1, 8'h07, pulses, addr_seen);
    check("aw07_pulses", pulses, 1);
    check("aw07_addr", 32'(addr_seen), 32'h0);
    check("aw07_din", 32'(DIN), 32'h07);
    bus_write(1'b0, 8'h38, pulses, addr_seen);
    check("dw38_pulses", pulses, 1);
    check("dw38_addr", 32'(addr_seen), 32'h1);
    check("dw38_din", 32'(DIN), 32'h38);
    bus_write(1'b1, 8'h30, pulses, addr_seen);
    check("aw30_nofm_pulses", pulses, 0);
    check("aw30_din", 32'(DIN), 32'h30);
    bus_write(1'b0, 8'h55, pulses, addr_seen);
    check("dw55_blocked", pulses, 0);

    bus_write(1'b1, 8'hE0, pulses, addr_seen);
    check("mode_pulses", pulses, 0);
    check("mode_addr_idle", 32'(ADDR), 32'h0);
    bus_write(1'b1, 8'h30, pulses, addr_seen);
    check("aw30_fm_pulses", pulses, 1);
    bus_write(1'b0, 8'h12, pulses, addr_seen);
    check("dw12_pulses", pulses, 1);

    for (int i = 0; i < N; i++) begin
      a[i] = 255; b[i] = 255; c[i] = 255; f[i] = 32'sh7FFF;
    end
    apply_inputs();
    sample(lat);
    check("sat_lat", lat, N + 2);
    check_ch("sat_l", CHANNEL_L, model(1'b1, 1'b1));
    check_ch("sat_r", CHANNEL_R, model(1'b0, 1'b1));
    @(negedge CLK);
    check("sat_valid_1cyc", 32'(OUT_VALID), 32'h0);
    check("sat_busy_done", 32'(BUSY), 32'h0);

    for (int it = 0; it < 8; it++) begin
      fm_en = 1'($urandom_range(0, 1));
      bus_write(1'b1, fm_en ? 8'hE0 : 8'hE2, pulses, addr_seen);
      for (int i = 0; i < N; i++) begin
        a[i] = int'($urandom_range(0, 255));
        b[i] = int'($urandom_range(0, 255));
        c[i] = int'($urandom_range(0, 255));
        f[i] = int'($signed(16'($urandom)));
      end
      apply_inputs();
      sample(lat);
      check("rnd_lat", lat, N + 2);
      check_ch("rnd_l", CHANNEL_L, model(1'b1, fm_en));
      check_ch("rnd_r", CHANNEL_R, model(1'b0, fm_en));
    end

    bus_write(1'b1, 8'hE2, pulses, addr_seen);
    for (int i = 0; i < N; i++) begin
      a[i] = 'h10; b[i] = 'h20; c[i] = 0; f[i] = 32'sh4000;
    end
    apply_inputs();
    @(negedge CLK);
    SAMPLE_CE = 1'b1;
    @(negedge CLK);
    SAMPLE_CE = 1'b0;
    nvalid = 0; vl = 0; vr = 0;
    for (int k = 1; k <= 14; k++) begin
      if (OUT_VALID === 1'b1) begin
        nvalid++;
        vl = int'(CHANNEL_L);
        vr = int'(CHANNEL_R);
        SAMPLE_CE = 1'b1;
      end else begin
        SAMPLE_CE = (k == 2);
      end
      @(negedge CLK);
    end
    SAMPLE_CE = 1'b0;
    check("busy_ce_nvalid", nvalid, 1);
    check("fmoff_l", vl, 'h80);
    check("fmoff_r", vr, 'h40);
    check_ch("fmoff_model_l", 12'(vl), model(1'b1, 1'b0));
    for (int i = 0; i < N; i++) a[i] = 'h7F;
    apply_inputs();
    repeat (3) @(negedge CLK);
    check_ch("hold_l", CHANNEL_L, 'h80);

    @(negedge CLK);
    SAMPLE_CE = 1'b1;
    @(negedge CLK);
    SAMPLE_CE = 1'b0;
    check("acc_busy", 32'(BUSY), 32'h1);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    check("abort_busy", 32'(BUSY), 32'h0);
    check("abort_valid", 32'(OUT_VALID), 32'h0);
    check_ch("abort_l", CHANNEL_L, 0);
    check_ch("abort_r", CHANNEL_R, 0);
    nvalid = 0;
    repeat (8) begin
      @(negedge CLK);
      if (OUT_VALID === 1'b1) nvalid++;
    end
    check("abort_no_valid", nvalid, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
